// File: rtl/msi_interrupt_requester_if.sv
// Endpoint-side MSI handshake bundle between the interrupt requester and the PCIe cfg_interrupt port.
// The master side is the requester; the slave side is the endpoint.
interface msi_interrupt_requester_if;
    logic       cfg_interrupt_n;
    logic [7:0] cfg_interrupt_di;
    logic       cfg_interrupt_assert_n;
    logic       cfg_interrupt_rdy_n;
    logic       cfg_interrupt_msienable;
    logic [2:0] cfg_interrupt_mmenable;

    modport master (
        output cfg_interrupt_n,
        output cfg_interrupt_di,
        output cfg_interrupt_assert_n,
        input  cfg_interrupt_rdy_n,
        input  cfg_interrupt_msienable,
        input  cfg_interrupt_mmenable
    );

    modport slave (
        input  cfg_interrupt_n,
        input  cfg_interrupt_di,
        input  cfg_interrupt_assert_n,
        output cfg_interrupt_rdy_n,
        output cfg_interrupt_msienable,
        output cfg_interrupt_mmenable
    );
endinterface

// File: rtl/msi_interrupt_requester.sv
// Merges rx/tx level interrupt requests into MSIs on the endpoint cfg_interrupt handshake,
// with round-robin arbitration, per-source vectors and an enforced idle gap after each MSI.
module msi_interrupt_requester #(
    parameter int unsigned GAP_CYCLES = 64,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             rx_send_interrupt_i,
    input  logic                             tx_send_interrupt_i,
    msi_interrupt_requester_if.master        cfg_if,
    output logic                             rx_int_sent_o,
    output logic                             tx_int_sent_o,
    output logic [31:0]                      int_count_o
);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    localparam logic             SrcRx   = 1'b0;
    localparam logic             SrcTx   = 1'b1;
    localparam logic [CNT_W-1:0] GapInit = CNT_W'(GAP_CYCLES);

    state_e           state_q, state_d;
    logic             cfg_n_q, cfg_n_d;
    logic [7:0]       di_q, di_d;
    logic             rx_sent_q, rx_sent_d;
    logic             tx_sent_q, tx_sent_d;
    logic [31:0]      count_q, count_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             last_q, last_d;
    logic             grant_q, grant_d;
    logic             pick;

    // Tie goes to whichever source was not served last.
    always_comb begin
        if (rx_send_interrupt_i && tx_send_interrupt_i) begin
            pick = ~last_q;
        end else begin
            pick = tx_send_interrupt_i ? SrcTx : SrcRx;
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_n_d   = cfg_n_q;
        di_d      = di_q;
        rx_sent_d = 1'b0;
        tx_sent_d = 1'b0;
        count_d   = count_q;
        gap_d     = gap_q;
        last_d    = last_q;
        grant_d   = grant_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_if.cfg_interrupt_msienable &&
                    (rx_send_interrupt_i || tx_send_interrupt_i)) begin
                    state_d = StReq;
                    cfg_n_d = 1'b0;
                    grant_d = pick;
                    di_d    = ((cfg_if.cfg_interrupt_mmenable != 3'd0) && (pick == SrcTx)) ?
                              8'd1 : 8'd0;
                end
            end
            StReq: begin
                // Request is never withdrawn; only the endpoint accept ends it.
                if (!cfg_if.cfg_interrupt_rdy_n) begin
                    state_d   = StGap;
                    cfg_n_d   = 1'b1;
                    rx_sent_d = (grant_q == SrcRx);
                    tx_sent_d = (grant_q == SrcTx);
                    count_d   = count_q + 32'd1;
                    last_d    = grant_q;
                    gap_d     = GapInit;
                end
            end
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cfg_n_q   <= 1'b1;
            di_q      <= 8'd0;
            rx_sent_q <= 1'b0;
            tx_sent_q <= 1'b0;
            count_q   <= 32'd0;
            gap_q     <= '0;
            last_q    <= SrcTx;
            grant_q   <= SrcRx;
        end else begin
            state_q   <= state_d;
            cfg_n_q   <= cfg_n_d;
            di_q      <= di_d;
            rx_sent_q <= rx_sent_d;
            tx_sent_q <= tx_sent_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
        end
    end

    assign cfg_if.cfg_interrupt_n        = cfg_n_q;
    assign cfg_if.cfg_interrupt_di       = di_q;
    assign cfg_if.cfg_interrupt_assert_n = 1'b1;
    assign rx_int_sent_o                 = rx_sent_q;
    assign tx_int_sent_o                 = tx_sent_q;
    assign int_count_o                   = count_q;

endmodule

// File: tb/tb_msi_interrupt_requester.sv
// Directed bench for msi_interrupt_requester with GAP_CYCLES=8; expected values are hand-derived.
module tb_msi_interrupt_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_req;
    logic        tx_req;
    logic        rx_sent;
    logic        tx_sent;
    logic [31:0] int_count;
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          bad;

    msi_interrupt_requester_if cfg_if ();

    msi_interrupt_requester #(
        .GAP_CYCLES (8),
        .CNT_W      (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .rx_send_interrupt_i (rx_req),
        .tx_send_interrupt_i (tx_req),
        .cfg_if              (cfg_if),
        .rx_int_sent_o       (rx_sent),
        .tx_int_sent_o       (tx_sent),
        .int_count_o         (int_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (cfg_if.cfg_interrupt_n == 1'b0) break;
            step();
        end
        check_eq(tag, {31'd0, cfg_if.cfg_interrupt_n}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        rx_req = 1'b0;
        tx_req = 1'b0;
        cfg_if.cfg_interrupt_rdy_n     = 1'b1;
        cfg_if.cfg_interrupt_msienable = 1'b1;
        cfg_if.cfg_interrupt_mmenable  = 3'd0;
        repeat (3) step();
        reset = 1'b0;

        check_eq("rst_cfg_n", {31'd0, cfg_if.cfg_interrupt_n}, 32'd1);
        check_eq("rst_di", {24'd0, cfg_if.cfg_interrupt_di}, 32'd0);
        check_eq("rst_assert_n", {31'd0, cfg_if.cfg_interrupt_assert_n}, 32'd1);
        check_eq("rst_sent", {30'd0, rx_sent, tx_sent}, 32'd0);
        check_eq("rst_count", int_count, 32'd0);

        // 1: rx held, accept on first REQ cycle, falling edges 11 cycles apart
        rx_req = 1'b1;
        step();
        check_eq("t1_req", {31'd0, cfg_if.cfg_interrupt_n}, 32'd0);
        check_eq("t1_di", {24'd0, cfg_if.cfg_interrupt_di}, 32'd0);
        cfg_if.cfg_interrupt_rdy_n = 1'b0;
        step();
        check_eq("t1_cfg_n_rel", {31'd0, cfg_if.cfg_interrupt_n}, 32'd1);
        check_eq("t1_rx_sent", {30'd0, rx_sent, tx_sent}, 32'd2);
        check_eq("t1_count1", int_count, 32'd1);
        step();
        check_eq("t1_pulse_end", {30'd0, rx_sent, tx_sent}, 32'd0);
        cyc = 2;
        for (int i = 0; i < 30; i++) begin
            step();
            cyc++;
            if (cfg_if.cfg_interrupt_n == 1'b0) break;
        end
        check_eq("t1_spacing", cyc, 32'd11);
        step();
        check_eq("t1_count2", int_count, 32'd2);
        check_eq("t1_rx_sent2", {30'd0, rx_sent, tx_sent}, 32'd2);
        rx_req = 1'b0;
        repeat (12) step();
        check_eq("t1_idle", {31'd0, cfg_if.cfg_interrupt_n}, 32'd1);

        // 2: both held, mmenable=1; rx was served last so tx goes first
        cfg_if.cfg_interrupt_mmenable = 3'b001;
        rx_req = 1'b1;
        tx_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            wait_req("t2_req");
            check_eq("t2_di", {24'd0, cfg_if.cfg_interrupt_di}, (g % 2 == 0) ? 32'd1 : 32'd0);
            step();
            check_eq("t2_sent", {30'd0, rx_sent, tx_sent}, (g % 2 == 0) ? 32'd1 : 32'd2);
        end
        rx_req = 1'b0;
        tx_req = 1'b0;
        check_eq("t2_count", int_count, 32'd6);
        repeat (12) step();

        // 3: tx only, mmenable=0, endpoint stalls 20 cycles
        cfg_if.cfg_interrupt_mmenable = 3'd0;
        cfg_if.cfg_interrupt_rdy_n    = 1'b1;
        tx_req = 1'b1;
        wait_req("t3_req");
        check_eq("t3_di", {24'd0, cfg_if.cfg_interrupt_di}, 32'd0);
        bad = 0;
        repeat (20) begin
            step();
            if (cfg_if.cfg_interrupt_n !== 1'b0 || cfg_if.cfg_interrupt_di !== 8'd0 ||
                rx_sent !== 1'b0 || tx_sent !== 1'b0) bad++;
        end
        check_eq("t3_hold", bad, 32'd0);
        cfg_if.cfg_interrupt_rdy_n = 1'b0;
        step();
        check_eq("t3_tx_sent", {30'd0, rx_sent, tx_sent}, 32'd1);
        check_eq("t3_count", int_count, 32'd7);
        tx_req = 1'b0;
        cfg_if.cfg_interrupt_rdy_n = 1'b1;
        repeat (12) step();

        // 4: MSI disabled blocks requests; enabling starts one a cycle later
        cfg_if.cfg_interrupt_msienable = 1'b0;
        rx_req = 1'b1;
        bad = 0;
        repeat (100) begin
            step();
            if (cfg_if.cfg_interrupt_n !== 1'b1) bad++;
        end
        check_eq("t4_blocked", bad, 32'd0);
        check_eq("t4_count", int_count, 32'd7);
        cfg_if.cfg_interrupt_msienable = 1'b1;
        step();
        check_eq("t4_req", {31'd0, cfg_if.cfg_interrupt_n}, 32'd0);

        // 5: enable and source drop mid-REQ; request still completes
        cfg_if.cfg_interrupt_msienable = 1'b0;
        rx_req = 1'b0;
        bad = 0;
        repeat (5) begin
            step();
            if (cfg_if.cfg_interrupt_n !== 1'b0) bad++;
        end
        check_eq("t5_held", bad, 32'd0);
        cfg_if.cfg_interrupt_rdy_n = 1'b0;
        step();
        check_eq("t5_sent", {30'd0, rx_sent, tx_sent}, 32'd2);
        check_eq("t5_cfg_n", {31'd0, cfg_if.cfg_interrupt_n}, 32'd1);
        check_eq("t5_count", int_count, 32'd8);
        cfg_if.cfg_interrupt_msienable = 1'b1;
        cfg_if.cfg_interrupt_rdy_n     = 1'b1;
        repeat (12) step();

        // 6: reset mid-REQ, then both high: rx wins the first tie
        rx_req = 1'b1;
        wait_req("t6_req");
        repeat (3) step();
        check_eq("t6_still_req", {31'd0, cfg_if.cfg_interrupt_n}, 32'd0);
        reset  = 1'b1;
        tx_req = 1'b1;
        cfg_if.cfg_interrupt_mmenable = 3'b001;
        step();
        check_eq("t6_rst_cfg_n", {31'd0, cfg_if.cfg_interrupt_n}, 32'd1);
        check_eq("t6_rst_count", int_count, 32'd0);
        reset = 1'b0;
        cfg_if.cfg_interrupt_rdy_n = 1'b0;
        wait_req("t6_req_rx");
        check_eq("t6_di_rx", {24'd0, cfg_if.cfg_interrupt_di}, 32'd0);
        step();
        check_eq("t6_rx_first", {30'd0, rx_sent, tx_sent}, 32'd2);
        check_eq("t6_count1", int_count, 32'd1);
        wait_req("t6_req_tx");
        check_eq("t6_di_tx", {24'd0, cfg_if.cfg_interrupt_di}, 32'd1);
        step();
        check_eq("t6_tx_next", {30'd0, rx_sent, tx_sent}, 32'd1);
        check_eq("t6_count2", int_count, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
